// File: rtl/cr_cfg_seq_pkg.sv
// Shared types and constants for the configuration-load sequencer:
// state encoding, bus address map and per-standard word counts.
package cr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL,
    ST_LDP,
    ST_DATA,
    ST_FIN,
    ST_ABRT
  } state_t;

  localparam logic [1:0] ADR_CTRL = 2'b00;
  localparam logic [1:0] ADR_VEC  = 2'b01;

  localparam logic [7:0] WC_STD0 = 8'd4;
  localparam logic [7:0] WC_STD1 = 8'd16;
  localparam logic [7:0] WC_STD2 = 8'd128;
  localparam logic [7:0] WC_STD3 = 8'd0;

  function automatic logic [7:0] word_count(input logic [1:0] std);
    case (std)
      2'b00:   word_count = WC_STD0;
      2'b01:   word_count = WC_STD1;
      2'b10:   word_count = WC_STD2;
      default: word_count = WC_STD3;
    endcase
  endfunction

endpackage

// File: rtl/cr_cfg_seq_if.sv
// Command, allocation-word stream and register-bus signals of the sequencer.
// master is the sequencer's view; slave is the surrounding system's view.
interface cr_cfg_seq_if;
  logic        CMD_STB;
  logic [1:0]  CMD_STD;
  logic        CMD_RDY;
  logic [31:0] WD_DAT;
  logic        WD_STB;
  logic        WD_ACK;
  logic [31:0] DAT_O;
  logic [1:0]  ADR_O;
  logic        WE_O;
  logic        STB_O;
  logic        ACK_I;
  logic        VEC_LD;
  logic        DONE;
  logic        ERR;

  modport master (
    input  CMD_STB, CMD_STD, WD_DAT, WD_STB, ACK_I,
    output CMD_RDY, WD_ACK, DAT_O, ADR_O, WE_O, STB_O, VEC_LD, DONE, ERR
  );

  modport slave (
    output CMD_STB, CMD_STD, WD_DAT, WD_STB, ACK_I,
    input  CMD_RDY, WD_ACK, DAT_O, ADR_O, WE_O, STB_O, VEC_LD, DONE, ERR
  );
endinterface

// File: rtl/cr_cfg_seq.sv
// Configuration-load sequencer: writes the standard code to the control
// register, restarts the vector counter, then streams N words with ACK timeout.
module cr_cfg_seq
  import cr_pkg::*;
#(
  parameter int unsigned TMO_MAX = 255
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  cr_cfg_seq_if.master  bus
);

  localparam int unsigned SW = (TMO_MAX < 2) ? 1 : $clog2(TMO_MAX + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(TMO_MAX - 1);

  state_t        state;
  state_t        next;
  logic [1:0]    std;
  logic [7:0]    cnt;
  logic [7:0]    wcnt;
  logic [SW-1:0] stall;

  logic        rdy;
  logic        stb;
  logic        we;
  logic [1:0]  adr;
  logic [31:0] dat;
  logic        wd_ack;
  logic        vec_ld;
  logic        done;
  logic        err;

  logic xfer;
  logic stalled;
  logic last_word;
  logic tmo;

  assign wcnt      = word_count(std);
  assign xfer      = stb & bus.ACK_I;
  assign stalled   = stb & ~bus.ACK_I;
  assign last_word = (cnt == wcnt - 8'd1);
  // Abort on the edge where this stall would make the count reach TMO_MAX.
  assign tmo       = stalled && (stall == STALL_LAST);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= ST_IDLE;
      std   <= '0;
      cnt   <= '0;
      stall <= '0;
    end else begin
      state <= next;
      if (state == ST_IDLE && bus.CMD_STB) begin
        std <= bus.CMD_STD;
        cnt <= '0;
      end else if (state == ST_DATA && xfer) begin
        cnt <= cnt + 8'd1;
      end
      // Starved stream keeps STB_O low, so the stall count simply holds.
      if (next != state || xfer) begin
        stall <= '0;
      end else if (stalled) begin
        stall <= stall + SW'(1);
      end
    end
  end

  always_comb begin
    next = state;
    case (state)
      ST_IDLE: if (bus.CMD_STB) next = ST_CTRL;
      ST_CTRL: begin
        if (xfer)     next = ST_LDP;
        else if (tmo) next = ST_ABRT;
      end
      ST_LDP:  next = (wcnt == 8'd0) ? ST_FIN : ST_DATA;
      ST_DATA: begin
        if (xfer && last_word) next = ST_FIN;
        else if (tmo)          next = ST_ABRT;
      end
      ST_FIN:  next = ST_IDLE;
      ST_ABRT: next = ST_IDLE;
      default: next = ST_IDLE;
    endcase
  end

  always_comb begin
    rdy    = 1'b0;
    stb    = 1'b0;
    we     = 1'b0;
    adr    = '0;
    dat    = '0;
    wd_ack = 1'b0;
    vec_ld = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    case (state)
      ST_IDLE: rdy = 1'b1;
      ST_CTRL: begin
        stb = 1'b1;
        we  = 1'b1;
        adr = ADR_CTRL;
        dat = {30'b0, std};
      end
      ST_LDP:  vec_ld = 1'b1;
      ST_DATA: begin
        stb    = bus.WD_STB;
        we     = 1'b1;
        adr    = ADR_VEC;
        dat    = bus.WD_DAT;
        wd_ack = bus.WD_STB & bus.ACK_I;
      end
      ST_FIN:  done = 1'b1;
      ST_ABRT: err  = 1'b1;
      default: rdy  = 1'b0;
    endcase
  end

  assign bus.CMD_RDY = rdy;
  assign bus.STB_O   = stb;
  assign bus.WE_O    = we;
  assign bus.ADR_O   = adr;
  assign bus.DAT_O   = dat;
  assign bus.WD_ACK  = wd_ack;
  assign bus.VEC_LD  = vec_ld;
  assign bus.DONE    = done;
  assign bus.ERR     = err;

endmodule

// File: doc/cr_cfg_seq.md
CR_CFG_SEQ -- requirements
Module: cr_cfg_seq

Interface
REQ-001 SHALL have parameter TMO_MAX, default 255, meaning the ACK stall limit in cycles before abort.
REQ-002 SHALL have port CLK_I, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port RST_I, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port CMD_STB, input, 1 bit: load request, sampled only when CMD_RDY=1.
REQ-005 SHALL have port CMD_STD, input, 2 bits: standard code captured with CMD_STB.
REQ-006 SHALL have port CMD_RDY, output, 1 bit: idle, able to accept a command.
REQ-007 SHALL have port WD_DAT, input, 32 bits: allocation word stream data.
REQ-008 SHALL have port WD_STB, input, 1 bit: WD_DAT valid.
REQ-009 SHALL have port WD_ACK, output, 1 bit: current stream word consumed this cycle.
REQ-010 SHALL have port DAT_O, output, 32 bits: bus write data.
REQ-011 SHALL have port ADR_O, output, 2 bits: bus address (00 control, 01 vector).
REQ-012 SHALL have port WE_O, output, 1 bit: bus write enable.
REQ-013 SHALL have port STB_O, output, 1 bit: bus strobe.
REQ-014 SHALL have port ACK_I, input, 1 bit: bus acknowledge from the register block.
REQ-015 SHALL have port VEC_LD, output, 1 bit: one-cycle pulse restarting the register block vector counter.
REQ-016 SHALL have port DONE, output, 1 bit: one-cycle pulse on successful load completion.
REQ-017 SHALL have port ERR, output, 1 bit: one-cycle pulse on timeout abort.

Function
REQ-018 SHALL implement states IDLE, CTRL, LDP, DATA, FIN, ABRT.
REQ-019 In IDLE, CMD_RDY SHALL be 1; CMD_STB=1 SHALL capture CMD_STD and go to CTRL next cycle; CMD_STB SHALL be ignored in all other states.
REQ-020 In CTRL: STB_O=1, WE_O=1, ADR_O=00, DAT_O={30'b0, std}; a transfer SHALL complete on any edge with STB_O=1 and ACK_I=1, then go to LDP.
REQ-021 LDP SHALL last exactly one cycle with VEC_LD=1 and STB_O=0, then go to DATA, or to FIN if the word count is 0.
REQ-022 Word count by std SHALL be 00->4, 01->16, 10->128, 11->0; the counter SHALL be 8 bits, cleared on entry to CTRL.
REQ-023 In DATA: STB_O=WD_STB, WE_O=1, ADR_O=01, DAT_O=WD_DAT combinationally; WD_ACK=STB_O&ACK_I; each completed transfer SHALL increment the counter.
REQ-024 The transfer completing the last word SHALL move DATA to FIN; no further stream word SHALL be acknowledged.
REQ-025 FIN SHALL last one cycle with DONE=1, then go to IDLE.
REQ-026 The stall counter SHALL increment on each cycle with STB_O=1 and ACK_I=0, clear on every completed transfer and on state change, and SHALL hold while WD_STB=0 in DATA (stream starvation never times out).
REQ-027 Stall counter reaching TMO_MAX SHALL go to ABRT; ABRT SHALL last one cycle with ERR=1 and STB_O=0, then go to IDLE.
REQ-028 Outside CTRL and DATA, STB_O, WE_O and WD_ACK SHALL be 0 and ADR_O, DAT_O SHALL be 0.
REQ-029 Back-to-back: CMD_STB in the IDLE cycle following FIN SHALL be accepted with no extra gap.

Reset
REQ-030 RST_I=1 at any edge, including mid-load, SHALL force IDLE, clear both counters and std, and drive CMD_RDY=1 with all other outputs 0 the following cycle; no DONE or ERR SHALL be emitted for the aborted load.

Structure
REQ-031 The state encoding, the four word-count constants and the address constants 00/01 SHALL live in a shared package (cr_pkg).
REQ-032 The block SHALL be a single module with no sub-modules; the word-count lookup SHALL be a package function.

Verification
REQ-033 std=00, WD_STB and ACK_I held 1 -> one control write DAT_O=0x0, VEC_LD pulse, 4 vector writes, DONE 1 cycle after the 4th ACK, 7 cycles from command to DONE.
REQ-034 std=10 with WD_STB toggled every other cycle -> exactly 128 WD_ACK pulses, no ERR, DONE once.
REQ-035 std=11 -> control write DAT_O=0x3, VEC_LD pulse, no vector writes, DONE on the cycle after LDP.
REQ-036 std=01, ACK_I forced 0 after the 5th word -> ERR pulse exactly 255 stalled cycles later, STB_O=0, CMD_RDY=1 next cycle, 5 WD_ACKs total.
REQ-037 RST_I pulsed during word 60 of std=10 -> outputs idle next cycle, no DONE/ERR; a new std=00 command then completes normally.
REQ-038 CMD_STB held 1 throughout a load -> a second load starts the cycle after FIN with no command lost or duplicated.
